slice_walk_ctrl: RTL

Sequencer for the 512-bit slice-extraction datapath. It holds a wide data word and walks a 32-bit extraction window across it from a start offset down to a stop offset, repeating for a programmed number of passes. Each window is presented on a valid/ready stream. A stall watchdog (egg timer) aborts the walk if the consumer stops accepting windows. It sits between the configuration/control logic and the downstream window consumer.

---
 rtl/slice_walk_if.sv | 28 ++
 rtl/slice_walk_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/slice_walk_if.sv
// Window stream between the slice-walk sequencer (master) and the window consumer (slave).
interface slice_walk_if #(
  parameter int WIN_W  = 32,
  parameter int OFF_W  = 9,
  parameter int PASS_W = 4
) ();
  logic              win_valid;
  logic              win_ready;
  logic [WIN_W-1:0]  win_data;
  logic [OFF_W-1:0]  win_off;
  logic [PASS_W-1:0] win_pass;

  modport master (
    output win_valid,
    output win_data,
    output win_off,
    output win_pass,
    input  win_ready
  );

  modport slave (
    input  win_valid,
    input  win_data,
    input  win_off,
    input  win_pass,
    output win_ready
  );
endinterface

// File: rtl/slice_walk_ctrl.sv
// Slice-walk sequencer: steps a WIN_W window from start_off down to stop_off across a
// held DATA_W word for a programmed number of passes, with a stall watchdog abort.
module slice_walk_ctrl #(
  parameter int DATA_W  = 512,
  parameter int WIN_W   = 32,
  parameter int OFF_W   = 9,
  parameter int PASS_W  = 4,
  parameter int TIMER_W = 7
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [OFF_W-1:0]  start_off,
  input  logic [OFF_W-1:0]  stop_off,
  input  logic [PASS_W-1:0] passes,
  slice_walk_if.master      win,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [OFF_W-1:0]   MAX_OFF    = OFF_W'(DATA_W - WIN_W);
  // Timer value whose increment reaches all-ones, i.e. the stall that fires the watchdog.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((2 ** TIMER_W) - 2);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   data_r;
  logic [OFF_W-1:0]    off_r;
  logic [PASS_W-1:0]   pass_r;
  logic [TIMER_W-1:0]  timer_r;
  logic                timeout_r;
  logic                cfg_err_r;
  logic [OFF_W-1:0]    start_off_r;
  logic [OFF_W-1:0]    stop_off_r;
  logic [PASS_W-1:0]   passes_r;

  logic                cfg_ok_s;
  logic                accept_s;
  logic                reject_s;
  logic                hs_s;
  logic                stall_s;
  logic                last_off_s;
  logic                last_pass_s;
  logic                wd_fire_s;
  logic                win_valid_s;
  logic                busy_s;
  logic                done_s;

  // Start qualification, handshake and end-of-walk / watchdog conditions.
  always_comb begin
    cfg_ok_s    = 1'b0;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    if ((passes != {PASS_W{1'b0}}) && (start_off >= stop_off) && (start_off <= MAX_OFF)) begin
      cfg_ok_s = 1'b1;
    end else begin
      cfg_ok_s = 1'b0;
    end
    if ((state_r == ST_IDLE) && start) begin
      accept_s = cfg_ok_s;
      reject_s = !cfg_ok_s;
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
    hs_s        = win_valid_s && win.win_ready;
    stall_s     = win_valid_s && !win.win_ready;
    last_off_s  = (off_r == stop_off_r);
    last_pass_s = (pass_r == (passes_r - PASS_W'(1)));
    wd_fire_s   = stall_s && (timer_r == TIMER_LAST);
  end

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (hs_s && last_off_s && last_pass_s) begin
          state_nxt_s = ST_DONE;
        end else if (wd_fire_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    win_valid_s = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        win_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
      end
      ST_EMIT: begin
        win_valid_s = 1'b1;
        busy_s      = 1'b1;
        done_s      = 1'b0;
      end
      ST_DONE: begin
        win_valid_s = 1'b0;
        busy_s      = 1'b1;
        done_s      = 1'b1;
      end
      default: begin
        win_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
      end
    endcase
  end

  // Data word, walk position, latched configuration, egg timer and status flags.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      data_r      <= {DATA_W{1'b0}};
      off_r       <= {OFF_W{1'b0}};
      pass_r      <= {PASS_W{1'b0}};
      timer_r     <= {TIMER_W{1'b0}};
      timeout_r   <= 1'b0;
      cfg_err_r   <= 1'b0;
      start_off_r <= {OFF_W{1'b0}};
      stop_off_r  <= {OFF_W{1'b0}};
      passes_r    <= {PASS_W{1'b0}};
    end else begin
      cfg_err_r <= reject_s;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            data_r <= load_data;
          end
          if (accept_s) begin
            off_r       <= start_off;
            pass_r      <= {PASS_W{1'b0}};
            timer_r     <= {TIMER_W{1'b0}};
            timeout_r   <= 1'b0;
            start_off_r <= start_off;
            stop_off_r  <= stop_off;
            passes_r    <= passes;
          end
        end
        ST_EMIT: begin
          if (hs_s) begin
            timer_r <= {TIMER_W{1'b0}};
            if (!last_off_s) begin
              off_r <= off_r - OFF_W'(1);
            end else if (!last_pass_s) begin
              pass_r <= pass_r + PASS_W'(1);
              off_r  <= start_off_r;
            end
          end else if (stall_s) begin
            timer_r <= timer_r + TIMER_W'(1);
            if (wd_fire_s) begin
              timeout_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign win.win_valid = win_valid_s;
  assign win.win_data  = data_r[off_r +: WIN_W];
  assign win.win_off   = off_r;
  assign win.win_pass  = pass_r;
  assign busy          = busy_s;
  assign done          = done_s;
  assign cfg_err       = cfg_err_r;
  assign timeout       = timeout_r;

endmodule
